// File: rtl/generic_fifo_sc_pkg.sv
// Shared definitions for the single-clock FIFO (generic_fifo_sc).
//
// Contents:
//   fifo_flags_t      - packed bundle of the registered status/error flags
//   flags_rst         - value every flag takes on reset or synchronous clear
//   fifo_depth()      - storage depth derived from the address width
//   fifo_levels_legal - checks af_level/ae_level against the depth
//
// No ports; imported by generic_fifo_sc and fifo_sc_mem.
package generic_fifo_sc_pkg;

    // Registered flags, kept together so reset and clear load them in one go.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    // An empty FIFO is always almost-empty because ae_level is never negative.
    localparam fifo_flags_t flags_rst = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    function automatic int fifo_depth(input int add_size);
        return 1 << add_size;
    endfunction

    // af_level must lie in 1..depth and ae_level in 0..depth-1.
    function automatic bit fifo_levels_legal(input int add_size,
                                             input int af_level,
                                             input int ae_level);
        int d;
        d = fifo_depth(add_size);
        return (af_level >= 1) && (af_level <= d) &&
               (ae_level >= 0) && (ae_level <= d - 1);
    endfunction

endpackage

// File: rtl/fifo_sc_mem.sv
// Storage array for the single-clock FIFO.
//
// A (1<<add_size) x data_size register array with one synchronous write port
// and one asynchronous read port. The array is deliberately not reset.
//
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module fifo_sc_mem
    import generic_fifo_sc_pkg::*;
#(
    parameter int data_size = 8,
    parameter int add_size  = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [add_size-1:0]  waddr,
    input  logic [data_size-1:0] wdata,
    input  logic [add_size-1:0]  raddr,
    output logic [data_size-1:0] rdata
);

    localparam int depth = fifo_depth(add_size);

    logic [data_size-1:0] mem [0:depth-1];

    // Synchronous write; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/generic_fifo_sc.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, optional first-word-fall-through read,
// synchronous clear and sticky overflow/underflow flags.
//
// Parameters:
//   data_size - word width
//   add_size  - address width, depth = 1<<add_size
//   fwft      - 0: registered read data, 1: head word shown combinationally
//   af_level  - almost_full when count >= af_level (1..depth)
//   ae_level  - almost_empty when count <= ae_level (0..depth-1)
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous reset, active low
//   clr          - synchronous clear, active high
//   data_in      - write data
//   wr_en        - write request
//   rd_en        - read request (pop acknowledge in FWFT mode)
//   data_out     - read data
//   full/empty   - count == depth / count == 0
//   almost_full  - count >= af_level
//   almost_empty - count <= ae_level
//   count        - occupancy 0..depth
//   overflow     - sticky, a write was rejected
//   underflow    - sticky, a read was rejected
module generic_fifo_sc
    import generic_fifo_sc_pkg::*;
#(
    parameter int data_size = 8,
    parameter int add_size  = 3,
    parameter int fwft      = 0,
    parameter int af_level  = 6,
    parameter int ae_level  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [data_size-1:0] data_in,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [data_size-1:0] data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [add_size:0]    count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int               depth     = fifo_depth(add_size);
    localparam logic [add_size:0] depth_c  = (add_size + 1)'(depth);
    localparam logic [add_size:0] af_c     = (add_size + 1)'(af_level);
    localparam logic [add_size:0] ae_c     = (add_size + 1)'(ae_level);
    localparam logic [add_size:0] one_c    = (add_size + 1)'(1);
    localparam bit               levels_ok = fifo_levels_legal(add_size, af_level, ae_level);

    logic [add_size:0]    wr_ptr;
    logic [add_size:0]    rd_ptr;
    logic [add_size:0]    count_next;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 mem_we;
    logic [data_size-1:0] mem_rdata;
    fifo_flags_t          flags;

    // A read needs data; a write into a full FIFO is only allowed when a
    // read frees a slot on the same edge.
    assign rd_acc = rd_en & ~flags.empty;
    assign wr_acc = wr_en & (~flags.full | rd_acc);

    // A clear cycle discards the write, so the array must not be touched.
    assign mem_we = wr_acc & ~clr;

    fifo_sc_mem #(
        .data_size (data_size),
        .add_size  (add_size)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[add_size-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[add_size-1:0]),
        .rdata (mem_rdata)
    );

    // Occupancy after this edge; a simultaneous read and write cancel out.
    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + one_c;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - one_c;
        end
    end

    // Pointers, count and flags. The level flags are computed from
    // count_next so they move on the same edge as count itself. Error flags
    // are sticky until reset or clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            flags  <= flags_rst;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            flags  <= flags_rst;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + one_c;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + one_c;
            end
            count              <= count_next;
            flags.full         <= (count_next == depth_c);
            flags.empty        <= (count_next == '0);
            flags.almost_full  <= (count_next >= af_c);
            flags.almost_empty <= (count_next <= ae_c);
            flags.overflow     <= flags.overflow  | (wr_en & ~wr_acc);
            flags.underflow    <= flags.underflow | (rd_en & flags.empty);
        end
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign overflow     = flags.overflow;
    assign underflow    = flags.underflow;

    // FWFT exposes the head of the queue directly; standard mode captures
    // the head into an output register only when a read is accepted.
    generate
        if (fwft != 0) begin : g_fwft
            assign data_out = mem_rdata;
        end else begin : g_std
            logic [data_size-1:0] data_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                end else if (rd_acc && !clr) begin
                    data_reg <= mem_rdata;
                end
            end

            assign data_out = data_reg;
        end
    endgenerate

    // Simulation-only diagnostics: illegal thresholds, rejected requests,
    // and a consistency check that count always equals the pointer distance.
    always_ff @(posedge clk) begin
        if (!levels_ok) begin
            $error("generic_fifo_sc: illegal af_level=%0d / ae_level=%0d for depth %0d",
                   af_level, ae_level, depth);
        end
        if (rst && !clr) begin
            if (wr_en && !wr_acc) begin
                $warning("generic_fifo_sc: write when full, data %h dropped", data_in);
            end
            if (rd_en && flags.empty) begin
                $warning("generic_fifo_sc: read when empty");
            end
            if (count != (wr_ptr - rd_ptr)) begin
                $error("generic_fifo_sc: count %0d disagrees with pointers %0d/%0d",
                       count, wr_ptr, rd_ptr);
            end
        end
    end

endmodule

// File: tb/tb_generic_fifo_sc.sv
// Self-checking bench for generic_fifo_sc.
//
// Two instances share every input: one in standard read mode, one in FWFT
// mode. A queue-based reference model tracks the expected contents, flags
// and standard-mode output register; each scenario task drives cycles and
// compares the instances against that model and against fixed values.
module tb_generic_fifo_sc;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          clr     = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   s_count, f_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    bit            m_ovf;
    bit            m_unf;

    generic_fifo_sc #(
        .data_size (DW), .add_size (AW), .fwft (0), .af_level (AF), .ae_level (AE)
    ) dut_std (
        .clk (clk), .rst (rst), .clr (clr), .data_in (data_in), .wr_en (wr_en),
        .rd_en (rd_en), .data_out (s_dout), .full (s_full), .empty (s_empty),
        .almost_full (s_af), .almost_empty (s_ae), .count (s_count),
        .overflow (s_ovf), .underflow (s_unf)
    );

    generic_fifo_sc #(
        .data_size (DW), .add_size (AW), .fwft (1), .af_level (AF), .ae_level (AE)
    ) dut_fwft (
        .clk (clk), .rst (rst), .clr (clr), .data_in (data_in), .wr_en (wr_en),
        .rd_en (rd_en), .data_out (f_dout), .full (f_full), .empty (f_empty),
        .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
        .overflow (f_ovf), .underflow (f_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_status();
        int n;
        n = q.size();
        return {4'(n), (n == 0), (n == DEPTH), (n >= AF), (n <= AE), m_ovf, m_unf};
    endfunction

    function automatic logic [9:0] std_status();
        return {s_count, s_empty, s_full, s_af, s_ae, s_ovf, s_unf};
    endfunction

    function automatic logic [9:0] fwft_status();
        return {f_count, f_empty, f_full, f_af, f_ae, f_ovf, f_unf};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    // Drive one clock cycle and advance the model by the FIFO's rules.
    task automatic drive(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        wr_en   = w;
        rd_en   = r;
        clr     = c;
        data_in = d;
        @(posedge clk);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            rd_ok = r && (q.size() != 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && (q.size() == 0)) m_unf = 1'b1;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        wr_en   = 1'b1;
        data_in = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({std_status(), fwft_status()} !== {exp_status(), exp_status()}) begin
            errors++;
            $display("FAIL reset_status: got %b/%b expected %b", std_status(), fwft_status(), exp_status());
        end
        checks++;
        if ({s_count, s_empty, s_ae, s_full, s_ovf, s_dout} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: count=%0d empty=%b ae=%b full=%b ovf=%b dout=%h", s_count, s_empty, s_ae, s_full, s_ovf, s_dout);
        end
        wr_en = 1'b0;
        rst   = 1'b1;
        #2;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
            checks++;
            if ({std_status(), fwft_status()} !== {exp_status(), exp_status()}) begin
                errors++;
                $display("FAIL fill_status[%0d]: got %b/%b expected %b", i, std_status(), fwft_status(), exp_status());
            end
        end
        checks++;
        if ({s_full, s_af} !== 2'b11) begin
            errors++;
            $display("FAIL fill_full: full=%b af=%b expected 1 1", s_full, s_af);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h18);
        checks++;
        if ({s_ovf, s_count} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL fill_overflow: ovf=%b count=%0d expected 1 8", s_ovf, s_count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (s_dout !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h expected %h", i, s_dout, 8'(8'h10 + i));
            end
            checks++;
            if ({std_status(), fwft_status()} !== {exp_status(), exp_status()}) begin
                errors++;
                $display("FAIL drain_status[%0d]: got %b/%b expected %b", i, std_status(), fwft_status(), exp_status());
            end
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if ({s_unf, s_empty, s_dout} !== {1'b1, 1'b1, 8'h17}) begin
            errors++;
            $display("FAIL drain_underflow: unf=%b empty=%b dout=%h expected 1 1 17", s_unf, s_empty, s_dout);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'h60 + i));
            checks++;
            if ({s_count, s_full, s_ovf, s_dout} !== {4'd8, 1'b1, 1'b0, 8'(8'h40 + i)}) begin
                errors++;
                $display("FAIL simul_full[%0d]: count=%0d full=%b ovf=%b dout=%h", i, s_count, s_full, s_ovf, s_dout);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (s_dout !== m_dout) begin
                errors++;
                $display("FAIL simul_order[%0d]: got %h expected %h", i, s_dout, m_dout);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 8'h77);
        checks++;
        if ({s_count, s_unf, s_empty} !== {4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL simul_empty: count=%0d unf=%b empty=%b expected 1 1 0", s_count, s_unf, s_empty);
        end
    endtask

    task automatic test_fwft();
        drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b0, 8'hA5);
        checks++;
        if ({f_dout, f_empty} !== {8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL fwft_head: dout=%h empty=%b expected a5 0", f_dout, f_empty);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h5A);
        drive(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if ({f_dout, s_dout} !== {8'h5A, 8'hA5}) begin
            errors++;
            $display("FAIL fwft_pop: fwft dout=%h std dout=%h expected 5a a5", f_dout, s_dout);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, '0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(k + 1));
            checks++;
            if (f_dout !== 8'(k + 1)) begin
                errors++;
                $display("FAIL wrap_fwft[%0d]: got %h expected %h", k, f_dout, 8'(k + 1));
            end
            drive(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if ({s_dout, s_empty} !== {8'(k + 1), 1'b1}) begin
                errors++;
                $display("FAIL wrap_data[%0d]: dout=%h empty=%b expected %h 1", k, s_dout, s_empty, 8'(k + 1));
            end
        end
    endtask

    task automatic test_clr();
        drive(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        checks++;
        if ({s_count, s_unf} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL clr_setup: count=%0d unf=%b expected 5 1", s_count, s_unf);
        end
        drive(1'b1, 1'b1, 1'b1, 8'hEE);
        checks++;
        if ({s_count, s_empty, s_ovf, s_unf, f_count} !== {4'd0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL clr_result: count=%0d empty=%b ovf=%b unf=%b fwft count=%0d", s_count, s_empty, s_ovf, s_unf, f_count);
        end
        checks++;
        if (s_dout !== m_dout) begin
            errors++;
            $display("FAIL clr_dout: got %h expected %h", s_dout, m_dout);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
        drive(1'b0, 1'b1, 1'b0, '0);
        wr_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({std_status(), fwft_status(), s_dout} !== {exp_status(), exp_status(), 8'h00}) begin
            errors++;
            $display("FAIL async_reset: got %b/%b dout=%h expected %b 00", std_status(), fwft_status(), s_dout, exp_status());
        end
        wr_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_random();
        int wr_pct;
        int rd_pct;
        for (int i = 0; i < 400; i++) begin
            wr_pct = ((i / 50) % 2 == 0) ? 75 : 25;
            rd_pct = 100 - wr_pct;
            drive(logic'($urandom_range(0, 99) < wr_pct),
                  logic'($urandom_range(0, 99) < rd_pct),
                  logic'($urandom_range(0, 99) < 2),
                  8'($urandom));
            checks++;
            if ({std_status(), fwft_status(), s_dout} !== {exp_status(), exp_status(), m_dout}) begin
                errors++;
                $display("FAIL random_state[%0d]: got %b/%b dout=%h expected %b dout=%h", i, std_status(), fwft_status(), s_dout, exp_status(), m_dout);
            end
            if (q.size() != 0) begin
                checks++;
                if (f_dout !== q[0]) begin
                    errors++;
                    $display("FAIL random_fwft[%0d]: got %h expected %h", i, f_dout, q[0]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_fwft();
        test_wrap();
        test_clr();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
